// File: rtl/decoder_strobe.sv
// 3-to-8 one-hot decoder that emits a strobe of HOLD cycles followed by GAP dead cycles,
// with a valid/ready accept handshake and a single-cycle done pulse on normal completion.
module decoder_strobe #(
  parameter int HOLD = 4,
  parameter int GAP  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] A,
  input  logic       en,
  input  logic       valid,
  output logic       ready,
  output logic [7:0] Y,
  output logic       busy,
  output logic       done
);

  localparam int MAXV = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW   = $clog2(MAXV + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [7:0]    y_reg, y_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic [7:0]    decoded;
  logic          accept;

  // One comparator per output line; the one-hot register is itself the latched code.
  for (genvar gi = 0; gi < 8; gi++) begin : g_dec
    assign decoded[gi] = (A == 3'(gi));
  end

  assign ready  = (state_reg == S_IDLE) & en;
  assign accept = valid & ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      y_reg     <= 8'h00;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      y_reg     <= y_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    y_next     = y_reg;
    done_next  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          y_next     = decoded;
          cnt_next   = CW'(HOLD - 1);
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        // Abort takes priority over the last-count transition.
        if (!en) begin
          y_next     = 8'h00;
          cnt_next   = '0;
          state_next = S_IDLE;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CW'(1);
        end else if (GAP > 0) begin
          y_next     = 8'h00;
          cnt_next   = CW'(GAP - 1);
          state_next = S_GAP;
        end else begin
          y_next     = 8'h00;
          state_next = S_IDLE;
          done_next  = 1'b1;
        end
      end
      S_GAP: begin
        if (!en) begin
          y_next     = 8'h00;
          cnt_next   = '0;
          state_next = S_IDLE;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CW'(1);
        end else begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        y_next     = 8'h00;
        cnt_next   = '0;
        state_next = S_IDLE;
      end
    endcase
    busy_next = (state_next != S_IDLE);
  end

  assign Y    = y_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_decoder_strobe.sv
// Directed bench for decoder_strobe: three instances cover the default timing,
// the HOLD=1/GAP=0 corner and a 255-cycle hold.
module tb_decoder_strobe;

  logic       clk;
  logic       rst;
  logic [2:0] A;
  logic       en;
  logic       valid0, valid1, valid2;
  logic       ready0, ready1, ready2;
  logic [7:0] Y0, Y1, Y2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;

  int vectors     = 0;
  int miscompares = 0;
  int n;
  logic [31:0] exp_y;

  decoder_strobe #(.HOLD(4), .GAP(1)) dut0 (
    .clk(clk), .rst(rst), .A(A), .en(en), .valid(valid0),
    .ready(ready0), .Y(Y0), .busy(busy0), .done(done0)
  );

  decoder_strobe #(.HOLD(1), .GAP(0)) dut1 (
    .clk(clk), .rst(rst), .A(A), .en(en), .valid(valid1),
    .ready(ready1), .Y(Y1), .busy(busy1), .done(done1)
  );

  decoder_strobe #(.HOLD(255), .GAP(1)) dut2 (
    .clk(clk), .rst(rst), .A(A), .en(en), .valid(valid2),
    .ready(ready2), .Y(Y2), .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; A = 3'd0;
    valid0 = 1'b0; valid1 = 1'b0; valid2 = 1'b0;

    // Reset asserted mid-cycle with random inputs: outputs clear without a clock.
    #2;
    A = 3'($urandom_range(0, 7)); en = 1'($urandom_range(0, 1)); valid0 = 1'($urandom_range(0, 1));
    rst = 1'b1;
    #1;
    chk("rst_y", 32'(Y0), 32'h00);
    chk("rst_busy", 32'(busy0), 32'h0);
    chk("rst_done", 32'(done0), 32'h0);
    chk("rst_ready_follows_en", 32'(ready0), 32'(en));
    en = 1'b1; valid0 = 1'b1; #1;
    chk("rst_ready_en1", 32'(ready0), 32'h1);
    tick();
    chk("rst_no_accept", 32'(busy0), 32'h0);
    chk("rst_no_accept_y", 32'(Y0), 32'h00);
    rst = 1'b0; valid0 = 1'b0;
    tick();

    // Single strobe, A=5.
    A = 3'd5; valid0 = 1'b1;
    tick();
    valid0 = 1'b0; A = 3'd2;
    for (int j = 1; j <= 4; j++) begin
      chk("single_y_hold", 32'(Y0), 32'h20);
      chk("single_busy_hold", 32'(busy0), 32'h1);
      chk("single_done_hold", 32'(done0), 32'h0);
      tick();
    end
    chk("single_y_gap", 32'(Y0), 32'h00);
    chk("single_busy_gap", 32'(busy0), 32'h1);
    chk("single_ready_gap", 32'(ready0), 32'h0);
    tick();
    chk("single_done", 32'(done0), 32'h1);
    chk("single_busy_end", 32'(busy0), 32'h0);
    chk("single_ready_end", 32'(ready0), 32'h1);
    tick();
    chk("single_done_once", 32'(done0), 32'h0);

    // Code sweep with valid held high; A is scrambled while busy.
    for (int k = 0; k < 8; k++) begin
      A = 3'(k); valid0 = 1'b1;
      tick();
      A = 3'(k + 5);
      for (int j = 1; j <= 6; j++) begin
        exp_y = (j <= 4) ? (32'h1 << k) : 32'h0;
        chk("sweep_y", 32'(Y0), exp_y);
        if (j == 6) chk("sweep_done", 32'(done0), 32'h1);
        else        chk("sweep_ready", 32'(ready0), 32'h0);
        if (j < 6) tick();
      end
    end
    valid0 = 1'b0;
    tick();

    // Abort in the second hold cycle of an A=3 strobe.
    A = 3'd3; valid0 = 1'b1;
    tick();
    valid0 = 1'b0;
    chk("abort_y1", 32'(Y0), 32'h08);
    tick();
    chk("abort_y2", 32'(Y0), 32'h08);
    en = 1'b0;
    tick();
    chk("abort_y", 32'(Y0), 32'h00);
    chk("abort_busy", 32'(busy0), 32'h0);
    chk("abort_done", 32'(done0), 32'h0);
    chk("abort_ready_en0", 32'(ready0), 32'h0);
    tick();
    chk("abort_no_done", 32'(done0), 32'h0);
    en = 1'b1; A = 3'd6; valid0 = 1'b1; #1;
    chk("abort_ready_back", 32'(ready0), 32'h1);
    tick();
    valid0 = 1'b0;
    chk("abort_new_y", 32'(Y0), 32'h40);
    chk("abort_new_busy", 32'(busy0), 32'h1);
    for (int j = 0; j < 5; j++) tick();
    chk("abort_new_done", 32'(done0), 32'h1);
    tick();

    // en falls on the last GAP edge: abort wins, no done.
    A = 3'd1; valid0 = 1'b1;
    tick();
    valid0 = 1'b0;
    for (int j = 0; j < 4; j++) tick();
    chk("lastcnt_gap_y", 32'(Y0), 32'h00);
    chk("lastcnt_gap_busy", 32'(busy0), 32'h1);
    en = 1'b0;
    tick();
    chk("lastcnt_done", 32'(done0), 32'h0);
    chk("lastcnt_busy", 32'(busy0), 32'h0);
    en = 1'b1;
    tick();

    // Asynchronous reset in the GAP phase, then a full-length strobe.
    A = 3'd2; valid0 = 1'b1;
    tick();
    valid0 = 1'b0;
    for (int j = 0; j < 4; j++) tick();
    chk("rgap_busy_before", 32'(busy0), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rgap_y", 32'(Y0), 32'h00);
    chk("rgap_busy", 32'(busy0), 32'h0);
    chk("rgap_done", 32'(done0), 32'h0);
    A = 3'd4; valid0 = 1'b1;
    tick();
    chk("rgap_no_accept", 32'(busy0), 32'h0);
    rst = 1'b0;
    tick();
    valid0 = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      exp_y = (j <= 4) ? 32'h10 : 32'h0;
      chk("rgap_y_after", 32'(Y0), exp_y);
      chk("rgap_busy_after", 32'(busy0), (j <= 5) ? 32'h1 : 32'h0);
      chk("rgap_done_after", 32'(done0), (j == 6) ? 32'h1 : 32'h0);
      if (j < 6) tick();
    end
    tick();

    // HOLD=1, GAP=0, A=7: two-cycle accept period.
    A = 3'd7; valid1 = 1'b1;
    tick();
    chk("c1_y", 32'(Y1), 32'h80);
    chk("c1_busy", 32'(busy1), 32'h1);
    chk("c1_done", 32'(done1), 32'h0);
    tick();
    chk("c1_y_off", 32'(Y1), 32'h00);
    chk("c1_done_on", 32'(done1), 32'h1);
    chk("c1_ready", 32'(ready1), 32'h1);
    tick();
    chk("c1_y_again", 32'(Y1), 32'h80);
    chk("c1_done_off", 32'(done1), 32'h0);
    valid1 = 1'b0;
    tick();
    chk("c1_done_again", 32'(done1), 32'h1);
    tick();

    // HOLD=255: count cycles with the line asserted.
    A = 3'd0; valid2 = 1'b1;
    tick();
    valid2 = 1'b0;
    n = 0;
    for (int i = 1; i <= 255; i++) begin
      if (Y2 == 8'h01) n++;
      tick();
    end
    chk("h255_count", 32'(n), 32'd255);
    chk("h255_y_gap", 32'(Y2), 32'h00);
    chk("h255_busy_gap", 32'(busy2), 32'h1);
    tick();
    chk("h255_done", 32'(done2), 32'h1);
    chk("h255_busy_end", 32'(busy2), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decoder_strobe.md
# decoder_strobe

Sequential 3-to-8 one-hot decoder with a valid/ready input handshake and timed output strobes. Accepts a 3-bit binary code, drives the matching one-hot line of `Y` for `HOLD` cycles, forces `Y` to zero for `GAP` cycles, then signals completion. It is the inverse of the 8-to-3 encoder in the same library. Its main use is driving select and strobe lines that need a guaranteed pulse width and a guaranteed dead time between pulses.

## Interface
- `HOLD`, default 4: cycles the one-hot output is held. Legal range 1..255.
- `GAP`, default 1: all-zero cycles after the hold. Legal range 0..255.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `A`  in  3  binary code to decode; sampled only on an accept.
- `en`  in  1  block enable; low blocks accepts and aborts any strobe in progress.
- `valid`  in  1  `A` is valid this cycle.
- `ready`  out  1  block can accept; combinational, `ready = (state==IDLE) & en`.
- `Y`  out  8  one-hot decoded output, registered; `Y[k]` high when the latched code is k.
- `busy`  out  1  registered; high whenever state ≠ IDLE.
- `done`  out  1  registered single-cycle pulse marking normal completion of a strobe.

## Operation
- State machine: IDLE, HOLD, GAP. Down-counter `cnt` of width ceil(log2(max(HOLD,GAP)+1)).
- **Reset:** `rst` high immediately gives state=IDLE, `Y`=8'h00, `busy`=0, `done`=0, `cnt`=0, code register=0. While `rst` is high, `ready` = `en`, but no accept takes effect.
- **IDLE:**
  - An accept is `valid & ready` at a rising edge.
  - On accept: latch `A`, `Y` ← 1<<A, `cnt` ← HOLD−1, state ← HOLD, `busy` ← 1.
  - `valid` without `ready` has no effect. `A` is ignored outside accept edges.
- **HOLD:**
  - `Y` is held constant.
  - If `cnt` ≠ 0: `cnt` decrements.
  - If `cnt` = 0 and GAP > 0: `Y` ← 0, `cnt` ← GAP−1, state ← GAP.
  - If `cnt` = 0 and GAP = 0: `Y` ← 0, state ← IDLE, `busy` ← 0, `done` ← 1.
- **GAP:**
  - `Y` = 0.
  - If `cnt` ≠ 0: `cnt` decrements.
  - If `cnt` = 0: state ← IDLE, `busy` ← 0, `done` ← 1.
- `done` is high for exactly one cycle per completed strobe. It is cleared on the next edge.
- **Abort:** `en` low at any edge while in HOLD or GAP gives `Y` ← 0, state ← IDLE, `busy` ← 0, `cnt` ← 0. No `done` pulse is issued. The latched code is discarded.
- `Y` is always either all-zero or exactly one-hot. It is never multi-hot, including across abort and reset.
- Every code 0..7 is legal. There is no invalid-input encoding.

## Timing
- Cycle numbering: accept at the rising edge ending cycle t.
- Cycles t+1 .. t+HOLD: `Y` one-hot, `busy`=1.
- Cycles t+HOLD+1 .. t+HOLD+GAP: `Y`=0, `busy`=1.
- Cycle t+HOLD+GAP+1: `Y`=0, `busy`=0, `done`=1, and `ready`=1 if `en` is high.
- Input-to-output latency: 1 cycle from accept to `Y`.
- Minimum accept-to-accept period: HOLD+GAP+1 cycles. A back-to-back accept is possible in the `done` cycle.
- `ready` is low during the whole of HOLD and GAP. `valid` held high across a strobe gives exactly one accept per period.
- **Reset mid-strobe:** outputs clear asynchronously, with no `done` pulse. The first accept is possible at the first edge after `rst` falls.
- **Simultaneous `en` fall and last-count edge:** the abort wins. `done` stays 0 and the state returns to IDLE.
- **Counter boundary:** HOLD=1 or GAP=1 means `cnt` is loaded with 0 and the phase lasts exactly one cycle. No wrap-around below 0 is ever used.

## Test plan
- **Reset check:** assert `rst` mid-cycle with random inputs. `Y`=00, `busy`=0 and `done`=0 without waiting for a clock. `ready` follows `en`.
- **Single strobe** (HOLD=4, GAP=1, A=5 accepted at edge t):
  - `Y`=8'b0010_0000 in cycles t+1..t+4.
  - `Y`=00 in cycle t+5.
  - `done`=1 in cycle t+6 only.
  - `busy`=1 for cycles t+1..t+5.
- **Code sweep:** `valid` held high, A = 0..7 stepped after each accept. `Y` = 01,02,04,08,10,20,40,80 in order, accepts exactly 6 cycles apart. `A` changes during busy are ignored.
- **Abort:** drop `en` in the 2nd HOLD cycle of an A=3 strobe.
  - `Y` = 00 the next cycle.
  - `busy`=0, no `done` pulse.
  - A new accept works after `en` returns high.
- **Async reset mid-GAP:** `Y`, `busy` and `done` are 0 immediately. The next accept after reset decodes correctly, with full HOLD length.
- **Parameter corners:**
  - HOLD=1, GAP=0, A=7: `Y`=80 for 1 cycle, `done` the next cycle, 2-cycle accept period.
  - HOLD=255: hold lasts exactly 255 cycles.
